// File: rtl/load_data_seq.sv
// rtl/load_data_seq.sv - splits a (pointer, length) request into row-read beats
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous abort of the current request
//   req_valid/ready    request handshake; req_pointer, req_len carry the request
//   beat_valid/ready   beat handshake toward the memory read port / lane select
//   beat_addr          row address (wraps modulo 2^ADDR_WIDTH)
//   beat_begin         first valid element within the row
//   beat_len           valid elements in the row (1..DATA_READ_WIDTH)
//   beat_first/last    first / final beat of the request
//   beat_idx           beat number within the request
module load_data_seq #(
    parameter int DATA_READ_WIDTH = 32,
    parameter int POINTER_WIDTH   = 30,
    parameter int ADDR_WIDTH      = 21,
    parameter int LEN_WIDTH       = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [POINTER_WIDTH-1:0] req_pointer,
    input  logic [LEN_WIDTH-1:0]     req_len,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ADDR_WIDTH-1:0]    beat_addr,
    output logic [LEN_WIDTH-1:0]     beat_begin,
    output logic [LEN_WIDTH-1:0]     beat_len,
    output logic                     beat_first,
    output logic                     beat_last,
    output logic [LEN_WIDTH-1:0]     beat_idx
);

    localparam int SHIFT = $clog2(DATA_READ_WIDTH);
    localparam logic [LEN_WIDTH:0] ROW_ELEMS = (LEN_WIDTH+1)'(DATA_READ_WIDTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    begin_q, rem_q, idx_q;

    logic [LEN_WIDTH:0]      room, span;
    logic [POINTER_WIDTH-1:0] row_ptr;
    logic                    unused_row;
    logic                    last, fire, accept, load;

    // Row index of the request; bits above ADDR_WIDTH are deliberately dropped.
    assign row_ptr    = req_pointer >> SHIFT;
    assign unused_row = ^row_ptr;

    // Widened by one bit so a full row (begin 0, rem >= W) does not overflow.
    assign room = ROW_ELEMS - {1'b0, begin_q};
    assign span = {1'b0, begin_q} + {1'b0, rem_q};
    assign last = (span <= ROW_ELEMS);

    assign beat_addr  = addr_q;
    assign beat_begin = begin_q;
    assign beat_idx   = idx_q;
    assign beat_len   = (room < {1'b0, rem_q}) ? room[LEN_WIDTH-1:0] : rem_q;
    assign beat_first = (idx_q == '0);
    assign beat_last  = last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        beat_valid = 1'b0;
        fire       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
            end
            BUSY: begin
                beat_valid = 1'b1;
                fire       = beat_ready;
                // A new request may ride on the last-beat fire for gapless streaming.
                req_ready  = !flush && beat_ready && last;
            end
            default: state_d = IDLE;
        endcase
        accept = req_valid && req_ready;
        load   = accept && (req_len != '0);
        if (flush) begin
            state_d = IDLE;
        end else if (load) begin
            state_d = BUSY;
        end else if (accept || (fire && last)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            begin_q <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
        end else if (!flush) begin
            if (load) begin
                addr_q  <= row_ptr[ADDR_WIDTH-1:0];
                begin_q <= LEN_WIDTH'(req_pointer[SHIFT-1:0]);
                rem_q   <= req_len;
                idx_q   <= '0;
            end else if (fire && !last) begin
                addr_q  <= addr_q + 1'b1;
                begin_q <= '0;
                rem_q   <= rem_q - beat_len;
                idx_q   <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_data_seq.sv
// tb/tb_load_data_seq.sv - self-checking bench for load_data_seq
module tb_load_data_seq;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        beat_ready = 1'b0;
    logic [29:0] req_pointer = '0;
    logic [10:0] req_len = '0;

    logic        req_ready, beat_valid, beat_first, beat_last;
    logic [20:0] beat_addr;
    logic [10:0] beat_begin, beat_len, beat_idx;

    logic        req_ready4, beat_valid4, beat_first4, beat_last4;
    logic [3:0]  beat_addr4;
    logic [10:0] beat_begin4, beat_len4, beat_idx4;

    load_data_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pointer(req_pointer), .req_len(req_len),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_addr(beat_addr), .beat_begin(beat_begin), .beat_len(beat_len),
        .beat_first(beat_first), .beat_last(beat_last), .beat_idx(beat_idx)
    );

    load_data_seq #(.ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_pointer(req_pointer), .req_len(req_len),
        .beat_valid(beat_valid4), .beat_ready(beat_ready),
        .beat_addr(beat_addr4), .beat_begin(beat_begin4), .beat_len(beat_len4),
        .beat_first(beat_first4), .beat_last(beat_last4), .beat_idx(beat_idx4)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int unsigned ptr;
        int          len;
        int          nb;
        int          a[3];
        int          b[3];
        int          l[3];
    } vec_t;

    vec_t vecs[6];

    typedef struct {
        longint row;
        int     bgn;
        int     len;
        bit     first;
        bit     last;
        int     idx;
    } beat_t;

    beat_t q[$];

    // Reference: walk the request row by row with plain arithmetic.
    task automatic push_beats(input longint ptr, input int len);
        longint row = ptr / W;
        int     b   = int'(ptr % W);
        int     rem = len;
        int     i   = 0;
        while (rem > 0) begin
            int l = (W - b < rem) ? (W - b) : rem;
            q.push_back('{row, b, l, (i == 0), (rem == l), i});
            rem -= l;
            row++;
            b = 0;
            i++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"},  longint'(req_ready), 1);
        chk({tag, " beat_valid"}, longint'(beat_valid), 0);
        chk({tag, " beat_first"}, longint'(beat_first), 1);
        chk({tag, " beat_last"},  longint'(beat_last), 1);
        chk({tag, " beat_addr"},  longint'(beat_addr), 0);
        chk({tag, " beat_addr4"}, longint'(beat_addr4), 0);
        chk({tag, " beat_begin"}, longint'(beat_begin), 0);
        chk({tag, " beat_len"},   longint'(beat_len), 0);
        chk({tag, " beat_idx"},   longint'(beat_idx), 0);
    endtask

    task automatic run_vec(input int vi);
        vec_t v = vecs[vi];
        string t = $sformatf("vec%0d", vi);
        req_pointer = 30'(v.ptr);
        req_len     = 11'(v.len);
        req_valid   = 1'b1;
        beat_ready  = 1'b1;
        @(negedge clk);
        chk({t, " req_ready"}, longint'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < v.nb; k++) begin
            @(negedge clk);
            chk({t, " valid"}, longint'(beat_valid), 1);
            chk({t, " addr"},  longint'(beat_addr), v.a[k]);
            chk({t, " addr4"}, longint'(beat_addr4), v.a[k] % 16);
            chk({t, " begin"}, longint'(beat_begin), v.b[k]);
            chk({t, " len"},   longint'(beat_len), v.l[k]);
            chk({t, " first"}, longint'(beat_first), (k == 0) ? 1 : 0);
            chk({t, " last"},  longint'(beat_last), (k == v.nb - 1) ? 1 : 0);
            chk({t, " idx"},   longint'(beat_idx), k);
        end
        tick();
        @(negedge clk);
        chk({t, " idle valid"}, longint'(beat_valid), 0);
        tick();
    endtask

    task automatic model_cycle();
        bit busy = (q.size() != 0);
        bit exp_rr;
        chk("rnd valid",  longint'(beat_valid), longint'(busy));
        chk("rnd valid4", longint'(beat_valid4), longint'(busy));
        if (busy) begin
            chk("rnd addr",  longint'(beat_addr), q[0].row % (longint'(1) << 21));
            chk("rnd addr4", longint'(beat_addr4), q[0].row % 16);
            chk("rnd begin", longint'(beat_begin), q[0].bgn);
            chk("rnd len",   longint'(beat_len), q[0].len);
            chk("rnd first", longint'(beat_first), longint'(q[0].first));
            chk("rnd last",  longint'(beat_last), longint'(q[0].last));
            chk("rnd idx",   longint'(beat_idx), q[0].idx);
        end
        exp_rr = !busy || (beat_ready && q[0].last);
        chk("rnd req_ready", longint'(req_ready), longint'(exp_rr));
        if (busy && beat_ready) void'(q.pop_front());
        if (req_valid && exp_rr && req_len != 0)
            push_beats(longint'(req_pointer), int'(req_len));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5,   10, 1, '{0, 0, 0},   '{5, 0, 0},  '{10, 0, 0}};
        vecs[1] = '{70,  30, 2, '{2, 3, 0},   '{6, 0, 0},  '{26, 4, 0}};
        vecs[2] = '{31,  65, 3, '{0, 1, 2},   '{31, 0, 0}, '{1, 32, 32}};
        vecs[3] = '{32,  32, 1, '{1, 0, 0},   '{0, 0, 0},  '{32, 0, 0}};
        vecs[4] = '{510,  4, 2, '{15, 16, 0}, '{30, 0, 0}, '{2, 2, 0}};
        vecs[5] = '{63,   2, 2, '{1, 2, 0},   '{31, 0, 0}, '{1, 1, 0}};

        #3;
        check_reset_outputs("reset");
        #9;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i);

        // zero-length request is consumed without producing a beat
        req_pointer = 30'd100;
        req_len     = 11'd0;
        req_valid   = 1'b1;
        @(negedge clk);
        chk("zero req_ready", longint'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("zero valid", longint'(beat_valid), 0);
        chk("zero ready after", longint'(req_ready), 1);
        tick();

        // flush during beat 1 of 3
        req_pointer = 30'd31;
        req_len     = 11'd65;
        req_valid   = 1'b1;
        beat_ready  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush idx", longint'(beat_idx), 1);
        chk("flush req_ready", longint'(req_ready), 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush valid after", longint'(beat_valid), 0);
        chk("flush ready after", longint'(req_ready), 1);
        tick();

        // asynchronous reset during beat 1
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_vec(0);

        // randomized traffic with backpressure against the reference model
        for (int c = 0; c < 3000; c++) begin
            req_valid   = ($urandom_range(0, 1) == 1);
            beat_ready  = ($urandom_range(0, 9) < 7);
            req_pointer = 30'($urandom & 32'h3FFF_FFFF);
            req_len     = ($urandom_range(0, 4) == 0) ? 11'd0 : 11'($urandom_range(1, 150));
            @(negedge clk);
            model_cycle();
            tick();
        end
        req_valid  = 1'b0;
        beat_ready = 1'b1;
        for (int c = 0; c < 400 && q.size() != 0; c++) begin
            @(negedge clk);
            model_cycle();
            tick();
        end
        chk("drain empty", longint'(q.size()), 0);
        @(negedge clk);
        chk("final valid", longint'(beat_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
